// File: rtl/ifmap_db_pkg.sv
// Shared types for the ifmap double-buffer read side: FSM encoding and
// counter-width helpers used by ifmap_db_reader.
package ifmap_db_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWITCH,
        ST_READ,
        ST_DRAIN
    } state_t;

    localparam int FIFO_DEPTH = 2;

    // Pass counter must hold NUM_PASSES itself once the final pass completes.
    function automatic int pass_width(input int num_passes);
        return $clog2(num_passes + 1);
    endfunction

endpackage

// File: rtl/ifmap_db_reader_skid_fifo.sv
// Two-entry skid FIFO absorbing the one-cycle read latency of the double
// buffer; the head register drives the streamed output word directly.
module db_rd_skid_fifo #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] tail;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: head is reset so the output word reads 0 after reset; tail is gated by count and needs none.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            head <= '0;
        end else if (pop) begin
            head <= (count == 2'd2) ? tail : din;
        end else if (push && count == 2'd0) begin
            head <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (push && (count == 2'd2 || (count == 2'd1 && !pop))) begin
            tail <= din;
        end
    end

endmodule

// File: rtl/ifmap_db_reader.sv
// Read-side controller for the ifmap double buffer: owns the bank swap and
// streams the read bank NUM_PASSES times over a valid/ready output.
module ifmap_db_reader
    import ifmap_db_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int BANK_ADDR_WIDTH = 9,
    parameter int BANK_DEPTH      = 200,
    parameter int NUM_WORDS       = 200,
    parameter int NUM_PASSES      = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fill_done,
    output logic                       wr_bank_free,
    output logic                       switch_banks,
    output logic                       ren,
    output logic [BANK_ADDR_WIDTH-1:0] radr,
    input  logic [DATA_WIDTH-1:0]      rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       busy,
    output logic                       fill_overrun
);

    localparam int PASS_W = pass_width(NUM_PASSES);
    localparam logic [BANK_ADDR_WIDTH-1:0] LAST_ADDR = BANK_ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [PASS_W-1:0]          LAST_PASS = PASS_W'(NUM_PASSES - 1);

    state_t                     state;
    logic [BANK_ADDR_WIDTH-1:0] addr;
    logic [PASS_W-1:0]          pass;
    logic                       fill_pending;
    logic                       rd_pend;
    logic [1:0]                 fifo_count;
    logic                       pop;
    logic [2:0]                 occ_after_pop;

    // A read is issued only if its word is guaranteed a FIFO slot when it lands.
    assign pop           = out_valid & out_ready;
    assign occ_after_pop = {1'b0, fifo_count} + {2'b00, rd_pend} - {2'b00, pop};
    assign ren           = (state == ST_READ) && (occ_after_pop < 3'(FIFO_DEPTH));

    assign radr          = addr;
    assign switch_banks  = (state == ST_SWITCH);
    assign wr_bank_free  = !fill_pending;
    assign out_valid     = (fifo_count != 2'd0);
    assign busy          = (state != ST_IDLE) || (fifo_count != 2'd0) || rd_pend;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state        <= ST_IDLE;
            addr         <= '0;
            pass         <= '0;
            rd_pend      <= 1'b0;
            fill_pending <= 1'b0;
            fill_overrun <= 1'b0;
        end else begin
            rd_pend <= ren;

            // A fill landing in the SWITCH cycle targets the bank just freed.
            if (fill_done && fill_pending && state != ST_SWITCH) begin
                fill_overrun <= 1'b1;
            end
            if (fill_done) begin
                fill_pending <= 1'b1;
            end else if (state == ST_SWITCH) begin
                fill_pending <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (fill_pending) begin
                        state <= ST_SWITCH;
                    end
                end
                ST_SWITCH: begin
                    addr  <= '0;
                    pass  <= '0;
                    state <= ST_READ;
                end
                ST_READ: begin
                    if (ren) begin
                        if (addr == LAST_ADDR) begin
                            addr <= '0;
                            pass <= pass + 1'b1;
                            if (pass == LAST_PASS) begin
                                state <= ST_DRAIN;
                            end
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!rd_pend && fifo_count == 2'd0) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    db_rd_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rd_pend),
        .din   (rdata),
        .pop   (pop),
        .count (fifo_count),
        .head  (out_data)
    );

endmodule

// File: tb/tb_ifmap_db_reader.sv
// Directed bench for ifmap_db_reader with a behavioural double-buffer model
// and a scoreboard of expected streams (word = bank tag + address).
module tb_ifmap_db_reader;

    localparam int DW = 64;
    localparam int AW = 9;
    localparam int NW = 200;
    localparam int NP = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fill_done;
    logic          wr_bank_free;
    logic          switch_banks;
    logic          ren;
    logic [AW-1:0] radr;
    logic [DW-1:0] rdata;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          fill_overrun;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] mem [2][NW];
    logic          rd_bank = 1'b0;

    logic [DW-1:0] bases[$];
    int            ren_idx = 0;
    int            con_idx = 0;
    int            occ = 0;
    int            cyc = 0;
    int            first_cyc = 0;
    int            stream_cycles = 0;
    int            n_switch = 0;
    logic          stalled = 1'b0;
    logic [DW-1:0] stall_data = '0;
    logic          pop;

    ifmap_db_reader #(
        .DATA_WIDTH (DW),
        .BANK_ADDR_WIDTH (AW),
        .BANK_DEPTH (200),
        .NUM_WORDS (NW),
        .NUM_PASSES (NP)
    ) dut (
        .clk (clk),
        .rst_n (rst_n),
        .fill_done (fill_done),
        .wr_bank_free (wr_bank_free),
        .switch_banks (switch_banks),
        .ren (ren),
        .radr (radr),
        .rdata (rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data (out_data),
        .busy (busy),
        .fill_overrun (fill_overrun)
    );

    always #5 clk = ~clk;

    // Double-buffer model: swap on switch_banks, one-cycle read latency.
    always @(posedge clk) begin
        if (switch_banks) rd_bank <= ~rd_bank;
        if (ren) rdata <= mem[rd_bank][radr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard sampled mid-cycle: data order, stall stability, credit, radr sequence.
    always @(negedge clk) begin
        if (rst_n) begin
            bases.delete();
            ren_idx = 0;
            con_idx = 0;
            occ     = 0;
            stalled = 1'b0;
        end else begin
            pop = out_valid && out_ready;
            if (stalled) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", out_data, stall_data);
            end
            if (switch_banks) begin
                n_switch++;
                check("switch_reads_done", 64'(ren_idx), 64'd0);
                check("switch_words_consumed", 64'(con_idx), 64'd0);
            end
            if (ren) begin
                check("credit", 64'((occ - int'(pop)) < 2), 64'd1);
                check("radr", 64'(radr), 64'(ren_idx % NW));
                ren_idx++;
                if (ren_idx == NW * NP) ren_idx = 0;
            end
            if (pop) begin
                check("sb_nonempty", 64'(bases.size() != 0), 64'd1);
                if (bases.size() != 0) begin
                    check("out_data", out_data, bases[0] + 64'(con_idx % NW));
                    if (con_idx == 0) first_cyc = cyc;
                    con_idx++;
                    if (con_idx == NW * NP) begin
                        con_idx = 0;
                        void'(bases.pop_front());
                        stream_cycles = cyc - first_cyc + 1;
                    end
                end
            end
            occ = occ + int'(ren) - int'(pop);
            stalled = out_valid && !out_ready;
            stall_data = out_data;
        end
        cyc++;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic fill_bank(input logic [DW-1:0] base);
        for (int a = 0; a < NW; a++) mem[!rd_bank][a] = base + 64'(a);
        bases.push_back(base);
    endtask

    task automatic pulse_fill();
        fill_done = 1'b1;
        cycle();
        fill_done = 1'b0;
    endtask

    task automatic wait_switch(input int max);
        bit found = 1'b0;
        for (int k = 0; k < max; k++) begin
            mid();
            if (switch_banks) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
        check("switch_timeout", 64'(found), 64'd1);
    endtask

    task automatic wait_idle(input int max, input bit rand_ready);
        bit done = 1'b0;
        for (int k = 0; k < max; k++) begin
            if (rand_ready) out_ready = (k >= 150 && k < 160) ? 1'b0 : 1'($urandom_range(0, 1));
            mid();
            if (!busy && wr_bank_free && bases.size() == 0) begin
                done = 1'b1;
                break;
            end
            cycle();
        end
        check("idle_timeout", 64'(done), 64'd1);
        check("idle_out_valid", 64'(out_valid), 64'd0);
        cycle();
        out_ready = 1'b1;
    endtask

    initial begin
        int sw0;
        rst_n     = 1'b1;
        fill_done = 1'b0;
        out_ready = 1'b0;
        repeat (3) cycle();
        mid();
        check("rst_wr_bank_free", 64'(wr_bank_free), 64'd1);
        check("rst_switch_banks", 64'(switch_banks), 64'd0);
        check("rst_ren", 64'(ren), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_fill_overrun", 64'(fill_overrun), 64'd0);
        cycle();
        rst_n = 1'b0;
        cycle();

        // 1: single bank, latency and sustained throughput
        fill_bank(64'hA000_0000_0000_0000);
        out_ready = 1'b1;
        fill_done = 1'b1;
        mid();
        check("t1_free_before", 64'(wr_bank_free), 64'd1);
        cycle();
        fill_done = 1'b0;
        mid();
        check("t1_free_pending", 64'(wr_bank_free), 64'd0);
        check("t1_no_switch_yet", 64'(switch_banks), 64'd0);
        cycle();
        mid();
        check("t1_switch_T", 64'(switch_banks), 64'd1);
        cycle();
        mid();
        check("t1_ren_T1", 64'(ren), 64'd1);
        check("t1_radr_T1", 64'(radr), 64'd0);
        check("t1_switch_pulse", 64'(switch_banks), 64'd0);
        check("t1_free_after", 64'(wr_bank_free), 64'd1);
        cycle();
        mid();
        check("t1_valid_T2", 64'(out_valid), 64'd0);
        cycle();
        mid();
        check("t1_valid_T3", 64'(out_valid), 64'd1);
        check("t1_data_T3", out_data, 64'hA000_0000_0000_0000);
        cycle();
        wait_idle(1000, 1'b0);
        check("t1_stream_cycles", 64'(stream_cycles), 64'(NW * NP));

        // 2: random backpressure with a 10-cycle stall window
        fill_bank(64'hC000_0000_0000_0000);
        pulse_fill();
        wait_idle(4000, 1'b1);

        // 3: next fill arrives during pass 0; switch waits for drain
        sw0 = n_switch;
        fill_bank(64'hA000_0000_0000_0000);
        pulse_fill();
        wait_switch(10);
        repeat (20) cycle();
        fill_bank(64'hB000_0000_0000_0000);
        pulse_fill();
        mid();
        check("t3_free_pending", 64'(wr_bank_free), 64'd0);
        cycle();
        wait_switch(1000);
        check("t3_free_at_switch", 64'(wr_bank_free), 64'd0);
        cycle();
        mid();
        check("t3_free_after_switch", 64'(wr_bank_free), 64'd1);
        cycle();
        wait_idle(1000, 1'b0);
        check("t3_switch_count", 64'(n_switch - sw0), 64'd2);

        // 4: double fill_done -> sticky overrun, one switch
        sw0 = n_switch;
        fill_bank(64'hD000_0000_0000_0000);
        fill_done = 1'b1;
        cycle();
        cycle();
        fill_done = 1'b0;
        mid();
        check("t4_overrun", 64'(fill_overrun), 64'd1);
        cycle();
        wait_idle(1000, 1'b0);
        repeat (4) cycle();
        mid();
        check("t4_overrun_sticky", 64'(fill_overrun), 64'd1);
        check("t4_single_switch", 64'(n_switch - sw0), 64'd1);
        check("t4_busy", 64'(busy), 64'd0);
        cycle();

        rst_n = 1'b1;
        cycle();
        rst_n = 1'b0;
        mid();
        check("rst_clears_overrun", 64'(fill_overrun), 64'd0);
        cycle();

        // 5: fill_done coincident with the SWITCH cycle
        sw0 = n_switch;
        fill_bank(64'hE000_0000_0000_0000);
        pulse_fill();
        wait_switch(10);
        fill_done = 1'b1;
        cycle();
        fill_done = 1'b0;
        mid();
        check("t5_free", 64'(wr_bank_free), 64'd0);
        check("t5_no_overrun", 64'(fill_overrun), 64'd0);
        fill_bank(64'hF000_0000_0000_0000);
        cycle();
        wait_idle(2000, 1'b0);
        check("t5_switch_count", 64'(n_switch - sw0), 64'd2);
        check("t5_no_overrun_end", 64'(fill_overrun), 64'd0);

        // 6: reset at word 57 of pass 1, then a clean restart
        fill_bank(64'h6000_0000_0000_0000);
        pulse_fill();
        begin
            bit reached = 1'b0;
            for (int k = 0; k < 1000; k++) begin
                mid();
                if (con_idx == NW + 57) begin
                    reached = 1'b1;
                    break;
                end
                cycle();
            end
            check("t6_reach_word57", 64'(reached), 64'd1);
        end
        cycle();
        rst_n = 1'b1;
        out_ready = 1'b0;
        cycle();
        rst_n = 1'b0;
        mid();
        check("t6_ren", 64'(ren), 64'd0);
        check("t6_out_valid", 64'(out_valid), 64'd0);
        check("t6_switch_banks", 64'(switch_banks), 64'd0);
        check("t6_wr_bank_free", 64'(wr_bank_free), 64'd1);
        check("t6_busy", 64'(busy), 64'd0);
        cycle();
        out_ready = 1'b1;
        fill_bank(64'h7000_0000_0000_0000);
        pulse_fill();
        wait_switch(10);
        cycle();
        mid();
        check("t6_restart_radr", 64'(radr), 64'd0);
        check("t6_restart_ren", 64'(ren), 64'd1);
        cycle();
        wait_idle(1000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
